// File: rtl/ema_lut_filter.sv
// Streaming EMA filter y[n] = floor(x/4) + floor(3*y[n-1]/4) on 8-bit samples,
// with valid/ready handshakes, one registered output stage and a settle counter.

module ema_lut_beta (
    input  logic [7:0] addr,
    output logic [9:0] data
);
    // Constant ROM of floor(3*a/4); read combinationally so the feedback loop closes in one cycle.
    logic [9:0] rom [256];

    generate
        for (genvar gi = 0; gi < 256; gi++) begin : g_rom
            assign rom[gi] = 10'((3 * gi) / 4);
        end
    endgenerate

    assign data = rom[addr];
endmodule

module ema_lut_filter #(
    parameter bit SEED_FIRST = 1'b1,
    parameter int SETTLE_N   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [15:0] sample_cnt,
    output logic       settled
);
    typedef enum logic {SEED, RUN} state_t;

    localparam logic [15:0] SETTLE_W = 16'(SETTLE_N);

    state_t      state_reg, state_next;
    logic [7:0]  y_reg;
    logic [7:0]  y_next;
    logic [7:0]  out_data_reg;
    logic        out_valid_reg;
    logic [15:0] sample_cnt_reg;

    logic [9:0]  beta_data;
    logic [8:0]  sum;
    logic [7:0]  filt;
    logic        accept;
    logic        unused_beta_hi;

    ema_lut_beta u_beta (
        .addr (y_reg),
        .data (beta_data)
    );

    assign unused_beta_hi = ^beta_data[9:8];

    assign in_ready   = ~rst & ~clear & (~out_valid_reg | out_ready);
    assign accept     = in_valid & in_ready;
    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign sample_cnt = sample_cnt_reg;
    assign settled    = (sample_cnt_reg >= SETTLE_W);

    always_comb begin
        sum        = {3'b000, in_data[7:2]} + {1'b0, beta_data[7:0]};
        filt       = sum[8] ? 8'hFF : sum[7:0];
        y_next     = filt;
        state_next = state_reg;
        if (state_reg == SEED && SEED_FIRST) begin
            y_next = in_data;
        end
        if (accept) begin
            state_next = RUN;
        end
        if (clear) begin
            state_next = SEED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= SEED;
            y_reg          <= 8'd0;
            out_data_reg   <= 8'd0;
            out_valid_reg  <= 1'b0;
            sample_cnt_reg <= 16'd0;
        end else begin
            state_reg <= state_next;
            if (clear) begin
                // Any pending output is dropped; a same-cycle out_ready handshake still completes.
                y_reg          <= 8'd0;
                out_data_reg   <= 8'd0;
                out_valid_reg  <= 1'b0;
                sample_cnt_reg <= 16'd0;
            end else if (accept) begin
                y_reg         <= y_next;
                out_data_reg  <= y_next;
                out_valid_reg <= 1'b1;
                if (sample_cnt_reg != 16'hFFFF) begin
                    sample_cnt_reg <= sample_cnt_reg + 16'd1;
                end
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end
endmodule

// File: doc/ema_lut_filter.md
# ema_lut_filter

Streaming exponential-moving-average filter core that computes y[n] = floor(x[n]/4) + floor(3·y[n-1]/4) on 8-bit unsigned samples. It sits directly downstream of the sample source and owns the feedback register. Each cycle it drives the stored y[n-1] into an internal `ema_lut_beta` instance and adds the returned beta term to the alpha term. Input and output use valid/ready handshakes with a single registered output stage, one sample per cycle sustained.

## Interface
- SEED_FIRST, 1: when 1, the first accepted sample after reset/clear loads y directly; when 0, y starts from 0 and the filter equation applies.
- SETTLE_N, 16: accepted-sample count at which `settled` asserts; legal range 1..65535.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of filter state, counter and output stage.
- in_valid  in  1  input sample present.
- in_ready  out  1  block accepts the sample this cycle.
- in_data  in  8  unsigned sample x[n].
- out_valid  out  1  out_data holds a filtered sample.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  8  unsigned filtered sample y[n].
- sample_cnt  out  16  accepted samples since reset/clear, saturating at 0xFFFF.
- settled  out  1  sample_cnt >= SETTLE_N.

## Operation
- State machine: SEED → RUN. Reset and clear enter SEED. The first accept moves SEED → RUN. RUN holds until rst or clear.
- Accept = in_valid & in_ready. The block computes in_ready = ~rst & ~clear & (~out_valid | out_ready).
- Beta term: `ema_lut_beta` addr = y_reg; the block uses data[7:0]. Upper bits are always 0 and are ignored.
- Alpha term: in_data[7:2], zero-extended.
- Sum is formed at 9 bits and saturated to 8'hFF. The maximum reachable value is 63 + 191 = 254, so saturation never fires for legal operation but must be present.
- On accept in SEED with SEED_FIRST=1: y_new = in_data.
- On any other accept (SEED with SEED_FIRST=0, or RUN): y_new = alpha + beta.
- On accept: y_reg <= y_new, out_data <= y_new, out_valid <= 1, and sample_cnt increments, saturating at 0xFFFF.
- out_valid clears on an out_ready handshake with no new accept in the same cycle.
- Accept and out_ready in the same cycle replaces out_data with no bubble.
- When out_valid=1 and out_ready=0, the output holds: out_data is stable, in_ready=0, and y_reg is unchanged.
- clear (priority over accept):
  - y_reg <= 0, out_data <= 0, out_valid <= 0, sample_cnt <= 0, state <= SEED.
  - Any pending output is discarded.
  - in_ready is 0 during the clear cycle.
- settled is combinational from sample_cnt.

## Timing
- Reset values:
  - state SEED; y_reg 0; out_data 0; out_valid 0; sample_cnt 0; settled 0.
  - in_ready 0 while rst is high and 1 on the first cycle after release.
- Latency: a sample accepted at edge k appears on out_data with out_valid=1 after edge k (visible in cycle k+1).
- Throughput: 1 sample/clock while out_ready=1.
- The feedback path y_reg → LUT → adder → y_reg is single-cycle combinational; there are no extra pipeline registers in the loop.
- rst asserted mid-stream:
  - All state clears immediately (asynchronous); an in-flight output is lost.
  - Behaviour after release is identical to power-up.
- clear asserted while out_valid=1 and out_ready=1: the handshake still completes this cycle (downstream consumes current out_data), and the clear takes effect at the same edge.
- A protocol violation (in_data changing while in_valid=1 and in_ready=0) needs no handling. Only accepted values matter.

## Test plan
- Seed hold, SEED_FIRST=1: accept 100 then 100 ×4 → out_data 100,100,100,100,100; sample_cnt ends at 5.
- Step response, SEED_FIRST=0: constant 200 ×4 → out_data 50, 87, 115, 136.
- Top-of-range rounding, SEED_FIRST=1: 255 ×5 → 255, 254, 253, 252, 252. Saturation never asserts.
- Backpressure:
  - Accept 200 then 40 with out_ready held 0 for 3 cycles after the first accept.
  - Required: out_data holds at the first result, in_ready=0 for those 3 cycles, and the second sample is accepted only on release.
  - Results are identical to the no-stall run.
- Clear and reset mid-stream:
  - Run 200 ×3, assert clear for 1 cycle, then send 60 → out_valid=0 after clear, sample_cnt=0, and the next output is 60 (seed).
  - Repeat with rst pulsed asynchronously between edges; all outputs must go to their reset values without a clock.
- Settle counter, SETTLE_N=4: settled=0 after 3 accepts and 1 after the 4th. Force sample_cnt near 0xFFFF and verify it saturates without wrapping.
